alu_flag_gen: RTL and testbench
===============================

Name: alu_flag_gen

Overview:
- Sequential ARM data-processing execution unit, directly upstream of the NZCV flag register.
- Accepts one operation per start pulse and computes the 32-bit result plus N, Z, C, V.
- Produces a registered flag-write strobe that drives the flag register's Z/C/N/V inputs and its enable.
- Data-processing ops take 1 cycle. MUL/MLA run on an iterative shift-add multiplier.

Parameters:
- WIDTH, 32, datapath width in bits.
- MUL_CYCLES, WIDTH, iteration count of the shift-add multiplier.

Ports:
- CLK  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only when busy=0
- opcode  input  4  ARM DP opcode: AND=0, EOR=1, SUB=2, RSB=3, ADD=4, ADC=5, SBC=6, RSC=7, TST=8, TEQ=9, CMP=10, CMN=11, ORR=12, MOV=13, BIC=14, MVN=15
- mul  input  1  1 = multiply op; opcode ignored
- acc  input  1  with mul=1: MLA (add acc_val)
- s_bit  input  1  update flags
- a  input  WIDTH  Rn operand
- b  input  WIDTH  shifter operand / Rm
- acc_val  input  WIDTH  MLA addend
- shifter_carry  input  1  carry-out from barrel shifter
- c_in, v_in  input  1 each  current C and V from the flag register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse, result/flags valid
- result  output  WIDTH  registered result
- result_we  output  1  high with done unless the op is TST/TEQ/CMP/CMN
- n_out, z_out, c_out, v_out  output  1 each  registered flags
- flag_we  output  1  high with done when s_bit=1 or the op is a test op

Behaviour:
- Reset: all outputs 0, FSM to IDLE. A reset mid-multiply aborts the operation with no done pulse.
- FSM states: IDLE, EXEC, MUL, DONE.
  - IDLE: start=1 latches all inputs. Goes to MUL if mul=1, else EXEC. busy rises next cycle.
  - EXEC: computes in one cycle, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - DP latency: start at cycle t gives done at t+2. start is ignored while busy=1.
- Arithmetic: uses a WIDTH+1-bit adder.
  - SUB/CMP/RSB: C = NOT borrow, i.e. C=1 when there is no borrow.
  - SBC/RSC: subtract NOT c_in.
  - ADC: adds c_in.
  - V = signed overflow of the two's-complement add/sub.
- Logical ops (AND, EOR, ORR, MOV, BIC, MVN, TST, TEQ): C = shifter_carry, V = v_in.
- All ops: N = result[WIDTH-1], Z = (result == 0).
- MUL path:
  - Accumulator is preset to acc_val if acc=1, else 0.
  - Each cycle: if multiplier LSB is set, add the multiplicand; shift multiplicand left and multiplier right.
  - After MUL_CYCLES iterations goes to DONE. Result is the low WIDTH bits.
  - Flags: N, Z from result; C = c_in; V = v_in.
  - MUL latency: start at t gives done at t+MUL_CYCLES+2.
- Outputs hold their values after DONE until the next done. result_we and flag_we are pulses coincident with done.
- Wrap-around: 0xFFFFFFFF + 1 gives result 0, C=1, Z=1, V=0.
- start held high: a new op is accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro: ALU_MUL_EARLY_TERM_EN.
- Defined: MUL goes to DONE as soon as the remaining multiplier bits are all zero. Minimum MUL latency is 3 cycles (done at t+3 when the multiplier is 0). Results and flags are identical to the full-length multiply.
- Undefined: fixed MUL_CYCLES iterations.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND..OP_MVN);
  - FSM state encoding;
  - the is_test_op and is_logical_op helper functions.
- One sub-module, alu_mul_seq: shift-add multiplier with start/busy/done and an accumulate preset. The top FSM instantiates it.

Test Plan:
- Reset held 2 cycles, then released: all outputs 0. ADD a=5, b=3, s=1: done at t+2, result=8, NZCV=0000, flag_we=1, result_we=1.
- CMP a=3, b=5: result=0xFFFFFFFE, N=1, Z=0, C=0, V=0, result_we=0, flag_we=1.
- ADD a=0x7FFFFFFF, b=1: N=1, V=1, C=0. ADD a=0xFFFFFFFF, b=1: Z=1, C=1, V=0.
- MOV with shifter_carry=1, v_in=1, s=1: C=1, V=1. Same op with s=0: flag_we=0.
- MLA a=7, b=6, acc_val=10, c_in=1, v_in=0: done at t+34, result=52, C=1, V=0. A start pulse issued mid-run is ignored.
- Reset at cycle 10 of a MUL: no done, busy=0 next cycle. With ALU_MUL_EARLY_TERM_EN defined, MUL with multiplier b=3, a=4 finishes in at most 5 cycles with result=12.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU flag generator slice.
//   - OP_* : 4-bit ARM data-processing opcodes
//   - state_t : top-level FSM encoding
//   - nzcv_t : packed flag bundle
//   - is_test_op / is_logical_op : opcode classifiers
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // TST/TEQ/CMP/CMN occupy 8..11: they set flags but never write a result.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_logical_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_flag_gen_if.sv
// alu_flag_gen_if: request/response bundle of the ALU flag generator.
//   request : start, opcode, mul, acc, s_bit, a, b, acc_val, shifter_carry, c_in, v_in
//   response: busy, done, result, result_we, n_out, z_out, c_out, v_out, flag_we
//   master = requester side, slave = ALU side.
interface alu_flag_gen_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       opcode;
  logic             mul;
  logic             acc;
  logic             s_bit;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_val;
  logic             shifter_carry;
  logic             c_in;
  logic             v_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             result_we;
  logic             n_out;
  logic             z_out;
  logic             c_out;
  logic             v_out;
  logic             flag_we;

  modport master (
    output start, opcode, mul, acc, s_bit, a, b, acc_val, shifter_carry, c_in, v_in,
    input  busy, done, result, result_we, n_out, z_out, c_out, v_out, flag_we
  );

  modport slave (
    input  start, opcode, mul, acc, s_bit, a, b, acc_val, shifter_carry, c_in, v_in,
    output busy, done, result, result_we, n_out, z_out, c_out, v_out, flag_we
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
//   CLK, reset (sync, active-high)
//   start_i   : load operands (ignored while running)
//   acc_i     : preset accumulator with acc_val_i (MLA), else 0
//   mcand_i / mplier_i : multiplicand / multiplier
//   busy_o    : iterating
//   done_o    : one-cycle pulse, product_o valid (low WIDTH bits)
// Optional: ALU_MUL_EARLY_TERM_EN stops as soon as no multiplier bits remain.
module alu_mul_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [WIDTH-1:0] acc_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, accum_q, accum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d, last_it;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    accum_d  = accum_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    last_it  = 1'b0;
    if (run_q) begin
      if (mplier_q[0]) accum_d = accum_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      last_it  = (cnt_q == CW'(MUL_CYCLES - 1));
`ifdef ALU_MUL_EARLY_TERM_EN
      // Remaining iterations would only shift the multiplicand; product is final.
      if (mplier_d == '0) last_it = 1'b1;
`endif
      if (last_it) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      accum_d  = acc_i ? acc_val_i : '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      accum_q  <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      accum_q  <= accum_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  assign busy_o    = run_q;
  assign done_o    = done_q;
  assign product_o = accum_q;
endmodule

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: sequential ARM data-processing unit feeding the NZCV flag register.
//   CLK, reset (sync, active-high)
//   bus (alu_flag_gen_if.slave): operation request in; result, NZCV flags,
//   result_we / flag_we strobes, busy and done out.
// DP ops: done two cycles after start. MUL/MLA: via alu_mul_seq.
// Optional: ALU_MUL_EARLY_TERM_EN (in alu_mul_seq) shortens multiplies.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input logic          CLK,
  input logic          reset,
  alu_flag_gen_if.slave bus
);
  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             mul_q, mul_d, s_q, s_d, sc_q, sc_d, ci_q, ci_d, vi_q, vi_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  nzcv_t            flg_q, flg_d;

  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  // Data-processing datapath: one WIDTH+1 adder covers every arithmetic op.
  logic [WIDTH-1:0] x, y, lres, dp_res;
  logic [WIDTH:0]   sum;
  logic             cy, dp_c, dp_v;

  always_comb begin
    x    = a_q;
    y    = b_q;
    cy   = 1'b0;
    case (op_q)
      OP_SUB, OP_CMP: begin y = ~b_q; cy = 1'b1; end
      OP_RSB:         begin x = b_q; y = ~a_q; cy = 1'b1; end
      OP_ADC:         cy = ci_q;
      OP_SBC:         begin y = ~b_q; cy = ci_q; end
      OP_RSC:         begin x = b_q; y = ~a_q; cy = ci_q; end
      default:        ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cy};

    case (op_q)
      OP_AND, OP_TST: lres = a_q & b_q;
      OP_EOR, OP_TEQ: lres = a_q ^ b_q;
      OP_ORR:         lres = a_q | b_q;
      OP_MOV:         lres = b_q;
      OP_BIC:         lres = a_q & ~b_q;
      OP_MVN:         lres = ~b_q;
      default:        lres = '0;
    endcase

    if (is_logical_op(op_q)) begin
      dp_res = lres;
      dp_c   = sc_q;
      dp_v   = vi_q;
    end else begin
      dp_res = sum[WIDTH-1:0];
      dp_c   = sum[WIDTH];
      dp_v   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end
  end

  assign mul_start = (state_q == S_IDLE) && bus.start && bus.mul && !mul_busy;

  alu_mul_seq #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .CLK       (CLK),
    .reset     (reset),
    .start_i   (mul_start),
    .acc_i     (bus.acc),
    .mcand_i   (bus.a),
    .mplier_i  (bus.b),
    .acc_val_i (bus.acc_val),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mul_d   = mul_q;
    s_d     = s_q;
    sc_d    = sc_q;
    ci_d    = ci_q;
    vi_d    = vi_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        op_d    = bus.opcode;
        mul_d   = bus.mul;
        s_d     = bus.s_bit;
        sc_d    = bus.shifter_carry;
        ci_d    = bus.c_in;
        vi_d    = bus.v_in;
        a_d     = bus.a;
        b_d     = bus.b;
        state_d = bus.mul ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        res_d   = dp_res;
        flg_d   = '{n: dp_res[WIDTH-1], z: (dp_res == '0), c: dp_c, v: dp_v};
        state_d = S_DONE;
      end
      S_MUL: if (mul_done) begin
        res_d   = mul_prod;
        flg_d   = '{n: mul_prod[WIDTH-1], z: (mul_prod == '0), c: ci_q, v: vi_q};
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mul_q   <= 1'b0;
      s_q     <= 1'b0;
      sc_q    <= 1'b0;
      ci_q    <= 1'b0;
      vi_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mul_q   <= mul_d;
      s_q     <= s_d;
      sc_q    <= sc_d;
      ci_q    <= ci_d;
      vi_q    <= vi_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  // Strobes decode the latched op so they line up exactly with done.
  assign bus.done      = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_EXEC) || (state_q == S_MUL);
  assign bus.result_we = bus.done && (mul_q || !is_test_op(op_q));
  assign bus.flag_we   = bus.done && (s_q || (!mul_q && is_test_op(op_q)));
  assign bus.result    = res_q;
  assign bus.n_out     = flg_q.n;
  assign bus.z_out     = flg_q.z;
  assign bus.c_out     = flg_q.c;
  assign bus.v_out     = flg_q.v;
endmodule

// File: tb/tb_alu_flag_gen.sv
module tb_alu_flag_gen;
  import alu_pkg::*;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_flag_gen_if #(.WIDTH(W)) bus();

  alu_flag_gen #(.WIDTH(W), .MUL_CYCLES(W)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request for a single cycle; returns 1 ns after the sampling edge.
  task automatic drive_op(input logic m, input logic ac, input logic s, input logic [3:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] av,
                          input logic sc, input logic ci, input logic vi);
    bus.mul = m; bus.acc = ac; bus.s_bit = s; bus.opcode = op;
    bus.a = a; bus.b = b; bus.acc_val = av;
    bus.shifter_carry = sc; bus.c_in = ci; bus.v_in = vi;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    reset = 1'b0;
    tick();
    n_chk++;
    if ({bus.busy, bus.done, bus.result_we, bus.flag_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {bus.busy, bus.done, bus.result_we, bus.flag_we});
    end
    n_chk++;
    if ({bus.result, bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: result %h nzcv %b want 0", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
  endtask

  task automatic test_add();
    drive_op(0, 0, 1, OP_ADD, 32'd5, 32'd3, 0, 0, 0, 0);
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_fail++; $display("FAIL add_t1: busy,done %b want 10", {bus.busy, bus.done});
    end
    tick();
    n_chk++;
    if ({bus.busy, bus.done, bus.result_we, bus.flag_we} !== 4'b0111) begin
      n_fail++; $display("FAIL add_t2_ctrl: got %b want 0111", {bus.busy, bus.done, bus.result_we, bus.flag_we});
    end
    n_chk++;
    if (bus.result !== 32'd8 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0000) begin
      n_fail++; $display("FAIL add_val: result %h nzcv %b want 00000008 0000", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
    n_chk++;
    if ({bus.done, bus.result_we, bus.flag_we} !== 3'b000 || bus.result !== 32'd8) begin
      n_fail++; $display("FAIL add_hold: done,rwe,fwe %b result %h want 000 00000008",
                         {bus.done, bus.result_we, bus.flag_we}, bus.result);
    end
  endtask

  task automatic test_cmp();
    drive_op(0, 0, 0, OP_CMP, 32'd3, 32'd5, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'hFFFF_FFFE || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b1000) begin
      n_fail++; $display("FAIL cmp_val: result %h nzcv %b want fffffffe 1000", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    n_chk++;
    if ({bus.done, bus.result_we, bus.flag_we} !== 3'b101) begin
      n_fail++; $display("FAIL cmp_we: done,rwe,fwe %b want 101", {bus.done, bus.result_we, bus.flag_we});
    end
    tick();
  endtask

  task automatic test_overflow();
    drive_op(0, 0, 1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'h8000_0000 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b1001) begin
      n_fail++; $display("FAIL ovf_pos: result %h nzcv %b want 80000000 1001", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
    drive_op(0, 0, 1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'h0 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0110) begin
      n_fail++; $display("FAIL ovf_wrap: result %h nzcv %b want 00000000 0110", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
  endtask

  task automatic test_carry_ops();
    // 5 - 3 - NOT(0) = 1, no borrow
    drive_op(0, 0, 1, OP_SBC, 32'd5, 32'd3, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'd1 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0010) begin
      n_fail++; $display("FAIL sbc: result %h nzcv %b want 00000001 0010", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
    drive_op(0, 0, 1, OP_ADC, 32'd1, 32'd1, 0, 0, 1, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'd3 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0000) begin
      n_fail++; $display("FAIL adc: result %h nzcv %b want 00000003 0000", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
    // RSB: 10 - 4 = 6
    drive_op(0, 0, 1, OP_RSB, 32'd4, 32'd10, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'd6 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0010) begin
      n_fail++; $display("FAIL rsb: result %h nzcv %b want 00000006 0010", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
  endtask

  task automatic test_logical();
    drive_op(0, 0, 1, OP_MOV, 32'h0, 32'h0, 0, 1, 0, 1);
    tick();
    n_chk++;
    if (bus.result !== 32'h0 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0111 ||
        {bus.result_we, bus.flag_we} !== 2'b11) begin
      n_fail++; $display("FAIL mov_s1: result %h nzcv %b we %b want 00000000 0111 11", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out}, {bus.result_we, bus.flag_we});
    end
    tick();
    drive_op(0, 0, 0, OP_MOV, 32'h0, 32'h0, 0, 1, 0, 1);
    tick();
    n_chk++;
    if ({bus.done, bus.result_we, bus.flag_we} !== 3'b110) begin
      n_fail++; $display("FAIL mov_s0: done,rwe,fwe %b want 110", {bus.done, bus.result_we, bus.flag_we});
    end
    tick();
    drive_op(0, 0, 1, OP_BIC, 32'hFF00_FF00, 32'hF0F0_F0F0, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (bus.result !== 32'h0F00_0F00 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0000) begin
      n_fail++; $display("FAIL bic: result %h nzcv %b want 0f000f00 0000", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
  endtask

  task automatic test_mla();
    int early = 0;
    drive_op(1, 1, 1, OP_AND, 32'd7, 32'd6, 32'd10, 0, 1, 0);
    for (int k = 2; k <= 33; k++) begin
      if (k == 10) begin
        bus.mul = 0; bus.opcode = OP_ADD; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      if (bus.done !== 1'b0) early++;
    end
    n_chk++;
    if (early != 0) begin
      n_fail++; $display("FAIL mla_early: %0d early done cycles want 0", early);
    end
    tick();
    n_chk++;
    if ({bus.done, bus.result_we, bus.flag_we} !== 3'b111) begin
      n_fail++; $display("FAIL mla_done: done,rwe,fwe %b want 111", {bus.done, bus.result_we, bus.flag_we});
    end
    n_chk++;
    if (bus.result !== 32'd52 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0010) begin
      n_fail++; $display("FAIL mla_val: result %h nzcv %b want 00000034 0010", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    early = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) early++;
    end
    n_chk++;
    if (early != 0 || bus.result !== 32'd52) begin
      n_fail++; $display("FAIL mla_ignored_start: %0d busy/done cycles result %h want 0 00000034",
                         early, bus.result);
    end
  endtask

  task automatic test_mul_small();
    int cyc = 1;
    drive_op(1, 0, 1, OP_AND, 32'd4, 32'd3, 32'd99, 0, 0, 0);
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_chk++;
`ifdef ALU_MUL_EARLY_TERM_EN
    if (bus.done !== 1'b1 || cyc > 5) begin
      n_fail++; $display("FAIL mul_latency: done %b after %0d cycles want 1 within 5", bus.done, cyc);
    end
`else
    if (bus.done !== 1'b1 || cyc != 34) begin
      n_fail++; $display("FAIL mul_latency: done %b after %0d cycles want 1 at 34", bus.done, cyc);
    end
`endif
    n_chk++;
    if (bus.result !== 32'd12 || {bus.n_out, bus.z_out, bus.c_out, bus.v_out} !== 4'b0000) begin
      n_fail++; $display("FAIL mul_val: result %h nzcv %b want 0000000c 0000", bus.result,
                         {bus.n_out, bus.z_out, bus.c_out, bus.v_out});
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    int spurious = 0;
    drive_op(1, 0, 1, OP_AND, 32'd7, 32'hFFFF_FFFF, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++) tick();
    reset = 1'b1;
    tick();
    n_chk++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 32'h0) begin
      n_fail++; $display("FAIL rst_mul: busy,done %b result %h want 00 00000000", {bus.busy, bus.done}, bus.result);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    n_chk++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL rst_mul_abort: %0d busy/done cycles after reset want 0", spurious);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.opcode = '0; bus.mul = 1'b0; bus.acc = 1'b0; bus.s_bit = 1'b0;
    bus.a = '0; bus.b = '0; bus.acc_val = '0;
    bus.shifter_carry = 1'b0; bus.c_in = 1'b0; bus.v_in = 1'b0;
    test_reset();
    test_add();
    test_cmp();
    test_overflow();
    test_carry_ops();
    test_logical();
    test_mla();
    test_mul_small();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
